// File: rtl/meter_pkg.sv
// Shared display constants for the meter timer: active-low 7-segment table {g..a}
// and the blank pattern.
package meter_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed so that element [d] is the pattern for BCD digit d (digit 9 listed first)
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        return (digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/bin2bcd_n.sv
// Combinational double-dabble: binary value below 10^DIGITS to DIGITS packed BCD nibbles.
module bin2bcd_n #(
    parameter int DIGITS = 4
) (
    input  logic [$clog2(10**DIGITS)-1:0] bin_i,
    output logic [4*DIGITS-1:0]           bcd_o
);

    localparam int BW = $clog2(10**DIGITS);

    // One add-3-then-shift stage per input bit, MSB first
    for (genvar gi = 0; gi < BW; gi++) begin : g_stage
        logic [4*DIGITS-1:0] in_w;
        logic [4*DIGITS-1:0] adj_w;
        logic [4*DIGITS-1:0] out_w;

        if (gi == 0) begin : g_first
            assign in_w = '0;
        end else begin : g_rest
            assign in_w = g_stage[gi-1].out_w;
        end

        for (genvar gd = 0; gd < DIGITS; gd++) begin : g_digit
            assign adj_w[4*gd +: 4] = (in_w[4*gd +: 4] >= 4'd5) ? in_w[4*gd +: 4] + 4'd3
                                                                : in_w[4*gd +: 4];
        end

        assign out_w = {adj_w[4*DIGITS-2:0], bin_i[BW-1-gi]};
    end

    assign bcd_o = g_stage[BW-1].out_w;

endmodule

// File: rtl/meter_timer_n.sv
// Parking-meter style countdown timer with multiplexed 7-segment display.
// Optional low-time display blinking is enabled by defining METER_BLINK_EN.
module meter_timer_n
    import meter_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000,
    parameter int ADD0       = 60,
    parameter int ADD1       = 120,
    parameter int ADD2       = 180,
    parameter int ADD3       = 300,
    parameter int PRESET0    = 15,
    parameter int PRESET1    = 185,
    parameter int LOW_THRESH = 200
) (
    input  logic                          clk,
    input  logic                          clr_n,
    input  logic [3:0]                    add_pulse,
    input  logic                          preset0,
    input  logic                          preset1,
    output logic [DIGITS-1:0]             an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(10**DIGITS)-1:0] remaining
);

    localparam int MAX_VAL = 10**DIGITS - 1;
    localparam int RW      = $clog2(10**DIGITS);
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int P0_SAT  = (PRESET0 > MAX_VAL) ? MAX_VAL : PRESET0;
    localparam int P1_SAT  = (PRESET1 > MAX_VAL) ? MAX_VAL : PRESET1;
`ifdef METER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic [RW-1:0]       rem_q, rem_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                tick_w, scan_wrap_w, blank_w;
    int                  sum_w;
    logic [4*DIGITS-1:0] bcd_w;
    logic [3:0]          digit_w;

    assign tick_w      = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign scan_wrap_w = (scan_cnt_q == SW'(SCAN_DIV - 1));

    // Presets win over everything; adds are summed and clamped before the tick decrement
    always_comb begin
        sum_w = int'(rem_q) + (add_pulse[0] ? ADD0 : 0) + (add_pulse[1] ? ADD1 : 0)
                            + (add_pulse[2] ? ADD2 : 0) + (add_pulse[3] ? ADD3 : 0);
        if (sum_w > MAX_VAL) begin
            sum_w = MAX_VAL;
        end
        if (preset1) begin
            rem_d = RW'(P1_SAT);
        end else if (preset0) begin
            rem_d = RW'(P0_SAT);
        end else if (tick_w && sum_w > 0) begin
            rem_d = RW'(sum_w - 1);
        end else begin
            rem_d = RW'(sum_w);
        end
    end

    always_comb begin
        tick_cnt_d = tick_w ? '0 : tick_cnt_q + TW'(1);
        scan_cnt_d = scan_wrap_w ? '0 : scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_wrap_w) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    bin2bcd_n #(.DIGITS(DIGITS)) u_bcd (
        .bin_i (rem_q),
        .bcd_o (bcd_w)
    );

    assign digit_w = bcd_w[{idx_q, 2'b00} +: 4];
    assign blank_w = BLINK_EN && (int'(rem_q) < LOW_THRESH) && (int'(tick_cnt_q) >= TICK_DIV / 2);

    always_comb begin
        an_d  = blank_w ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d = blank_w ? SEG_BLANK : seg_encode(digit_w);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rem_q      <= '0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            rem_q      <= rem_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign remaining = rem_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_meter_timer_n.sv
// Self-checking bench for meter_timer_n (DIGITS=4, TICK_DIV=10, SCAN_DIV=2) against a
// cycle-level arithmetic model; honours METER_BLINK_EN when defined.
`timescale 1ns/1ps
module tb_meter_timer_n;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 10;
    localparam int SCAN_DIV = 2;
    localparam int MAXV     = 9999;
    localparam int P0       = 15;
    localparam int P1       = 185;
    localparam int LOW      = 200;
`ifdef METER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [3:0]  add_pulse = 4'b0000;
    logic        preset0 = 1'b0;
    logic        preset1 = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [13:0] remaining;

    int checks = 0;
    int failures = 0;

    // Reference model state: seconds left and clock edges since reset release
    int         m_rem = 0;
    int         m_n = 0;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    int         add_sec [4] = '{60, 120, 180, 300};
    logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    meter_timer_n #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .add_pulse (add_pulse),
        .preset0   (preset0),
        .preset1   (preset1),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by one edge, compare everything.
    task automatic cyc(input logic [3:0] add, input logic p0, input logic p1);
        int  s, idx, v;
        bit  blank;
        add_pulse = add;
        preset0   = p0;
        preset1   = p1;
        @(posedge clk);
        idx   = (m_n / SCAN_DIV) % DIGITS;
        blank = BLINK && (m_rem < LOW) && ((m_n % TICK_DIV) >= TICK_DIV / 2);
        v = m_rem;
        for (int k = 0; k < idx; k++) v = v / 10;
        m_an  = blank ? 4'hF : ~(4'b0001 << idx);
        m_seg = blank ? 7'h7F : seg_ref[v % 10];
        if (p1) begin
            m_rem = P1;
        end else if (p0) begin
            m_rem = P0;
        end else begin
            s = m_rem;
            for (int b = 0; b < 4; b++) if (add[b]) s += add_sec[b];
            if (s > MAXV) s = MAXV;
            if ((m_n % TICK_DIV) == TICK_DIV - 1 && s > 0) s--;
            m_rem = s;
        end
        m_n++;
        #1;
        check_val("remaining", remaining, m_rem);
        check_val("an", an, m_an);
        check_val("seg", seg, m_seg);
        check_val("dp", dp, 1);
        add_pulse = 4'b0000;
        preset0   = 1'b0;
        preset1   = 1'b0;
    endtask

    task automatic do_reset();
        add_pulse = 4'b0000;
        preset0   = 1'b0;
        preset1   = 1'b0;
        clr_n     = 1'b0;
        #1;
        check_val("rst_remaining", remaining, 0);
        check_val("rst_an", an, 4'hF);
        check_val("rst_seg", seg, 7'h7F);
        check_val("rst_dp", dp, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        m_rem = 0;
        m_n   = 0;
    endtask

    initial begin
        int         blanks;
        int         r;
        logic [3:0] seen;
        logic [3:0] radd;
        #2;
        $display("txn reset at start");
        do_reset();

        $display("txn preset1 held 3 cycles");
        repeat (3) cyc(4'b0000, 1'b0, 1'b1);
        repeat (6) cyc(4'b0000, 1'b0, 1'b0);
        check_val("preset_185", remaining, 185);
        cyc(4'b0000, 1'b0, 1'b0);
        check_val("preset_184", remaining, 184);

        $display("txn reset mid-count remaining=%0d", remaining);
        repeat (4) cyc(4'b0000, 1'b0, 1'b0);
        do_reset();

        $display("txn add 0011 on first tick");
        repeat (9) cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0011, 1'b0, 1'b0);
        check_val("simul_add", remaining, 179);

        $display("txn saturation run");
        do_reset();
        repeat (16) cyc(4'b1111, 1'b0, 1'b0);
        check_val("sat_full", remaining, 9999);
        for (int i = 0; i < 1200 && remaining != 14'd9900; i++) cyc(4'b0000, 1'b0, 1'b0);
        check_val("reach_9900", remaining, 9900);
        if ((m_n % TICK_DIV) == TICK_DIV - 1) cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        check_val("sat_add", remaining, 9999);
        repeat (10) cyc(4'b0000, 1'b0, 1'b0);
        check_val("sat_dec", remaining, 9998);

        $display("txn preset0, blink window and zero floor");
        do_reset();
        cyc(4'b0000, 1'b1, 1'b0);
        blanks = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0000, 1'b0, 1'b0);
            if (an == 4'hF) blanks++;
        end
        check_val("blink_count", blanks, BLINK ? 5 : 0);
        for (int i = 0; i < 300 && remaining != 14'd1; i++) cyc(4'b0000, 1'b0, 1'b0);
        check_val("reach_1", remaining, 1);
        repeat (20) cyc(4'b0000, 1'b0, 1'b0);
        check_val("zero_floor", remaining, 0);
        repeat (20) cyc(4'b0000, 1'b0, 1'b0);
        check_val("zero_stay", remaining, 0);

        $display("txn display 1234");
        do_reset();
        repeat (4) cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 400 && remaining != 14'd1234; i++) cyc(4'b0000, 1'b0, 1'b0);
        check_val("reach_1234", remaining, 1234);
        seen = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0000, 1'b0, 1'b0);
            case (an)
                4'b1110: begin check_val("disp_d0", seg, seg_ref[4]); seen[0] = 1'b1; end
                4'b1101: begin check_val("disp_d1", seg, seg_ref[3]); seen[1] = 1'b1; end
                4'b1011: begin check_val("disp_d2", seg, seg_ref[2]); seen[2] = 1'b1; end
                4'b0111: begin check_val("disp_d3", seg, seg_ref[1]); seen[3] = 1'b1; end
                default: check_val("disp_an_onehot", an, 4'b1110);
            endcase
        end
        check_val("disp_all_digits", seen, 4'hF);

        $display("txn random phase");
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 10) begin
                radd = 4'($urandom);
                $display("txn rnd n=%0d add=%b model=%0d", m_n, radd, m_rem);
                cyc(radd, 1'b0, 1'b0);
            end else if (r < 15) begin
                $display("txn rnd n=%0d preset0", m_n);
                cyc(4'b0000, 1'b1, 1'b0);
            end else if (r < 20) begin
                $display("txn rnd n=%0d preset1", m_n);
                cyc(4'b0000, 1'b0, 1'b1);
            end else if (r < 23) begin
                $display("txn rnd n=%0d reset remaining=%0d", m_n, remaining);
                do_reset();
            end else begin
                cyc(4'b0000, 1'b0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog obs=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/meter_timer_n.md
METER_TIMER_N -- requirements
Module: meter_timer_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD display digits (1..6).
REQ-002 SHALL have parameter TICK_DIV, default 100000000, clk cycles per 1-second tick.
REQ-003 SHALL have parameter SCAN_DIV, default 100000, clk cycles per display digit slot.
REQ-004 SHALL have parameters ADD0..ADD3, defaults 60/120/180/300, seconds added per add_pulse bit.
REQ-005 SHALL have parameters PRESET0/PRESET1, defaults 15/185, load values in seconds.
REQ-006 SHALL have parameter LOW_THRESH, default 200, low-time blink threshold in seconds.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port clr_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port add_pulse  input  4  pre-debounced single-cycle add requests, bit i adds ADDi.
REQ-010 SHALL have port preset0  input  1  level, load PRESET0.
REQ-011 SHALL have port preset1  input  1  level, load PRESET1.
REQ-012 SHALL have port an  output  DIGITS  digit enables, active low.
REQ-013 SHALL have port seg  output  7  segments {g..a}, active low.
REQ-014 SHALL have port dp  output  1  decimal point, active low, held 1.
REQ-015 SHALL have port remaining  output  clog2(10^DIGITS)  binary seconds remaining.

Function
REQ-016 SHALL hold remaining as binary, MAX = 10^DIGITS-1.
REQ-017 SHALL assert an internal tick for one clk every TICK_DIV cycles (free-running counter 0..TICK_DIV-1, tick at TICK_DIV-1).
REQ-018 SHALL, when preset1 high, load PRESET1 next edge; else when preset0 high, load PRESET0; adds and tick ignored that cycle.
REQ-019 SHALL otherwise compute s = min(remaining + sum of ADDi for all set add_pulse bits, MAX), all bits in same cycle summed.
REQ-020 SHALL then load s-1 if tick and s>0, else s; remaining never wraps below 0 or above MAX.
REQ-021 SHALL accept adds while remaining==0 (meter restarts).
REQ-022 SHALL saturate preset values above MAX to MAX.
REQ-023 SHALL scan digits via index 0..DIGITS-1 advancing every SCAN_DIV cycles, wrapping to 0; digit 0 = least significant.
REQ-024 SHALL drive an with exactly one bit low (bit = index) when display enabled, all ones when blanked.
REQ-025 SHALL drive seg with the standard 0-9 active-low pattern of the BCD digit selected by index; 7'h7F when blanked.
REQ-026 SHALL show all digits including leading zeros.
REQ-027 SHALL register an/seg (one-cycle latency from index/value change).

Reset
REQ-028 SHALL on clr_n low asynchronously set remaining=0, tick counter=0, scan counter=0, index=0, an=all ones, seg=7'h7F, dp=1.
REQ-029 SHALL abandon any pending add/preset at reset; first tick occurs TICK_DIV cycles after clr_n rises.

Configuration
REQ-030 SHALL use macro METER_BLINK_EN.
REQ-031 SHALL with METER_BLINK_EN defined blank the display whenever (remaining < LOW_THRESH, including 0) and tick counter >= TICK_DIV/2.
REQ-032 SHALL without METER_BLINK_EN keep the display steadily enabled.

Structure
REQ-033 SHALL place the 7-segment digit encoding table and blank constant in shared package meter_pkg.
REQ-034 SHALL use one sub-module bin2bcd_n (combinational double-dabble, parameter DIGITS) converting remaining to DIGITS BCD nibbles.

Verification (DIGITS=4, TICK_DIV=10, SCAN_DIV=2)
REQ-035 SHALL verify reset: clr_n low mid-count -> remaining=0, an=4'b1111, seg=7'h7F immediately.
REQ-036 SHALL verify preset: preset1 high 3 cycles then low -> remaining=185, decrements to 184 after 10 cycles.
REQ-037 SHALL verify simultaneous adds: remaining=0, add_pulse=4'b0011 coinciding with tick -> remaining=179.
REQ-038 SHALL verify saturation: remaining=9900, add_pulse=4'b1000 -> remaining=9999; further ticks decrement from 9999.
REQ-039 SHALL verify zero floor: remaining=1, two ticks -> remaining=0 and stays 0.
REQ-040 SHALL verify display: remaining=1234 -> an cycles 1110,1101,1011,0111 with seg patterns 4,3,2,1; with METER_BLINK_EN and remaining=15, an=1111 for tick counter 5..9.
